// File: rtl/multi_bcd_display.sv
// Multi-channel value to seven-segment display driver with decimal (double-dabble) or hex digits.
// Latency: decimal CHANNELS*(IN_WIDTH+1)+1 edges from accepted start to done, hex CHANNELS+1 edges.
// No backpressure: start is only sampled when idle; a start while busy is dropped, not queued.
module multi_bcd_display #(
    parameter int CHANNELS = 2,
    parameter int IN_WIDTH = 6,
    parameter int DIGITS   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         mode_hex,
    input  logic                         blank_lz,
    input  logic [CHANNELS*IN_WIDTH-1:0] in,
    output logic                         busy,
    output logic                         done,
    output logic [CHANNELS-1:0]          ovf,
    output logic [CHANNELS*DIGITS*7-1:0] ssd
);

    // BCD digits needed to hold 2^IN_WIDTH-1
    localparam int NB = (IN_WIDTH + 2) / 3;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int EW = IN_WIDTH + 4 * DIGITS;
    localparam int SW = 4 * (NB + DIGITS);

    localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(IN_WIDTH - 1);
    localparam logic [6:0]    SEG_BLANK = 7'h7F;
    localparam logic [6:0]    SEG_DASH  = 7'h3F;
    localparam logic [CHANNELS*DIGITS*7-1:0] BLANK_ALL = {(CHANNELS*DIGITS){SEG_BLANK}};

    typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;

    state_t                         state;
    logic [CHANNELS*IN_WIDTH-1:0]   in_lat;
    logic                           hex_lat;
    logic                           blank_lat;
    logic [CW-1:0]                  ch_idx;
    logic [CW-1:0]                  ch_nxt;
    logic [BW-1:0]                  bit_cnt;
    logic [4*NB-1:0]                scratch;
    logic [4*NB-1:0]                scratch_adj;
    logic [IN_WIDTH-1:0]            value;
    logic [CHANNELS*DIGITS*7-1:0]   shadow_ssd;
    logic [CHANNELS-1:0]            shadow_ovf;

    logic [IN_WIDTH-1:0]            cur_val;
    logic [EW-1:0]                  hex_ext;
    logic [SW-1:0]                  dec_ext;
    logic                           ovf_c;
    logic                           seen_nz;
    logic [3:0]                     nib;
    logic [DIGITS*7-1:0]            dig_codes;

    // Active-low segments, bit0=a .. bit6=g
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    assign ch_nxt = ch_idx + 1'b1;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < NB; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Digit codes and overflow for the channel currently in WRITE
    always_comb begin
        cur_val   = in_lat[ch_idx*IN_WIDTH +: IN_WIDTH];
        hex_ext   = {{(4*DIGITS){1'b0}}, cur_val};
        dec_ext   = {{(4*DIGITS){1'b0}}, scratch};
        ovf_c     = hex_lat ? |(hex_ext >> (4*DIGITS)) : |(dec_ext >> (4*DIGITS));
        seen_nz   = 1'b0;
        nib       = 4'h0;
        dig_codes = '0;
        // Walk from the most significant digit so blanking stops at the first nonzero digit
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib = hex_lat ? hex_ext[4*d +: 4] : dec_ext[4*d +: 4];
            if (ovf_c)
                dig_codes[7*d +: 7] = SEG_DASH;
            else if (blank_lat && (d != 0) && !seen_nz && (nib == 4'h0))
                dig_codes[7*d +: 7] = SEG_BLANK;
            else
                dig_codes[7*d +: 7] = seg7(nib);
            if (nib != 4'h0)
                seen_nz = 1'b1;
        end
    end

    // Control FSM; results build up in shadow registers and reach the outputs together in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= '0;
            ssd        <= BLANK_ALL;
            shadow_ssd <= BLANK_ALL;
            shadow_ovf <= '0;
            in_lat     <= '0;
            hex_lat    <= 1'b0;
            blank_lat  <= 1'b0;
            ch_idx     <= '0;
            bit_cnt    <= '0;
            scratch    <= '0;
            value      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        in_lat    <= in;
                        hex_lat   <= mode_hex;
                        blank_lat <= blank_lz;
                        ch_idx    <= '0;
                        scratch   <= '0;
                        bit_cnt   <= '0;
                        value     <= in[IN_WIDTH-1:0];
                        busy      <= 1'b1;
                        state     <= mode_hex ? WRITE : CONVERT;
                    end
                end
                CONVERT: begin
                    {scratch, value} <= {scratch_adj, value} << 1;
                    bit_cnt          <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT)
                        state <= WRITE;
                end
                WRITE: begin
                    shadow_ssd[ch_idx*DIGITS*7 +: DIGITS*7] <= dig_codes;
                    shadow_ovf[ch_idx]                      <= ovf_c;
                    if (ch_idx == LAST_CH) begin
                        state <= DONE;
                    end else begin
                        ch_idx <= ch_nxt;
                        if (!hex_lat) begin
                            scratch <= '0;
                            bit_cnt <= '0;
                            value   <= in_lat[ch_nxt*IN_WIDTH +: IN_WIDTH];
                            state   <= CONVERT;
                        end
                    end
                end
                DONE: begin
                    ssd   <= shadow_ssd;
                    ovf   <= shadow_ovf;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_bcd_display.sv
// Directed bench for multi_bcd_display: default instance plus a one-digit instance for overflow.
// Inputs driven and outputs sampled on the falling edge; every wait on done is cycle-bounded.
// Expected segment codes are hand-computed constants.
module tb_multi_bcd_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode_hex;
    logic        blank_lz;
    logic [11:0] in;

    logic        busy, done;
    logic [1:0]  ovf;
    logic [27:0] ssd;
    logic        busy1, done1;
    logic [1:0]  ovf1;
    logic [13:0] ssd1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    multi_bcd_display #(.CHANNELS(2), .IN_WIDTH(6), .DIGITS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_hex(mode_hex), .blank_lz(blank_lz),
        .in(in), .busy(busy), .done(done), .ovf(ovf), .ssd(ssd)
    );

    multi_bcd_display #(.CHANNELS(2), .IN_WIDTH(6), .DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mode_hex(mode_hex), .blank_lz(blank_lz),
        .in(in), .busy(busy1), .done(done1), .ovf(ovf1), .ssd(ssd1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Starts one conversion and waits for done; lat counts edges after the accepting edge
    task automatic run_conv(input logic [11:0] v, input logic hex, input logic blz,
                            output int lat, output int busy_cyc);
        @(negedge clk);
        in = v; mode_hex = hex; blank_lz = blz; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_cyc = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    // Partial-update watch: ssd may only change in the cycle done is high
    logic        mon_en = 1'b0;
    int          partial_err = 0;
    logic [27:0] prev_ssd;
    always @(negedge clk) begin
        if (mon_en && (ssd !== prev_ssd) && !done) partial_err++;
        prev_ssd = ssd;
    end

    initial begin
        int lat, bcyc, dones, k;
        logic [11:0] v6 [3];
        logic [27:0] e6 [3];

        rst = 1'b1; start = 1'b0; mode_hex = 1'b0; blank_lz = 1'b0; in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf",  ovf, 0);
        check("rst_ssd",  ssd, 28'hFFFFFFF);
        check("rst_ssd1", ssd1, 14'h3FFF);
        rst = 1'b0;

        // Decimal 47 / 12
        run_conv({6'd12, 6'd47}, 1'b0, 1'b0, lat, bcyc);
        check("dec_lat",  lat, 15);
        check("dec_busy_cycles", bcyc, 15);
        check("dec_busy_low_at_done", busy, 0);
        check("dec_ssd",  ssd, {7'h79, 7'h24, 7'h19, 7'h78});
        check("dec_ovf",  ovf, 2'b00);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        // Hex 2F / 05
        run_conv({6'h05, 6'h2F}, 1'b1, 1'b0, lat, bcyc);
        check("hex_lat", lat, 3);
        check("hex_ssd", ssd, {7'h40, 7'h12, 7'h24, 7'h0E});
        check("hex_ovf", ovf, 2'b00);

        // Leading-zero blanking, 5 / 0
        run_conv({6'd0, 6'd5}, 1'b0, 1'b1, lat, bcyc);
        check("blank_ssd", ssd, {7'h7F, 7'h40, 7'h7F, 7'h12});
        check("blank_ovf", ovf, 2'b00);

        // Overflow on the one-digit instance, 63 / 9
        run_conv({6'd9, 6'd63}, 1'b0, 1'b0, lat, bcyc);
        check("ovf_lat",  lat, 15);
        check("ovf_done1", done1, 1);
        check("ovf_ovf1", ovf1, 2'b01);
        check("ovf_ssd1", ssd1, {7'h10, 7'h3F});
        check("ovf_ssd2digit", ssd, {7'h40, 7'h10, 7'h02, 7'h30});
        check("ovf_ovf2digit", ovf, 2'b00);

        // Reset five edges into a conversion
        @(negedge clk);
        in = {6'd12, 6'd47}; mode_hex = 1'b0; blank_lz = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ssd",  ssd, 28'hFFFFFFF);
        check("abort_ovf",  ovf, 0);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        // Start while busy is ignored
        @(negedge clk);
        in = {6'd33, 6'd21}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int j = 0; j < 40; j++) begin
            if (j == 3) begin start = 1'b1; in = {6'd5, 6'd5}; end
            if (j == 4) start = 1'b0;
            @(negedge clk);
            if (done) dones++;
        end
        check("busy_start_dones", dones, 1);
        check("busy_start_ssd", ssd, {7'h30, 7'h30, 7'h24, 7'h79});

        // Back-to-back with start held high
        v6[0] = {6'd12, 6'd47}; e6[0] = {7'h79, 7'h24, 7'h19, 7'h78};
        v6[1] = {6'd0,  6'd5 }; e6[1] = {7'h40, 7'h40, 7'h40, 7'h12};
        v6[2] = {6'd63, 6'd9 }; e6[2] = {7'h02, 7'h30, 7'h40, 7'h10};
        @(negedge clk);
        mon_en = 1'b1;
        in = v6[0]; mode_hex = 1'b0; blank_lz = 1'b0; start = 1'b1;
        @(negedge clk);
        in = v6[1];
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (!done && k < 60) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("b2b_lat%0d", i), k, 15);
            check($sformatf("b2b_ssd%0d", i), ssd, e6[i]);
            @(negedge clk);
            if (i < 2) begin
                check($sformatf("b2b_restart%0d", i), busy, 1);
                if (i == 0) in = v6[2];
                else in = {6'd0, 6'd0};
            end else begin
                start = 1'b0;
            end
        end
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        check("b2b_no_partial", partial_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
